// File: rtl/adc_pkg.sv
// Shared types and constants for the serial ADC reader.
package adc_pkg;

  localparam int ADC_BITS = 16;
  localparam int GAP_MULT = 2;
  // Three guard bits are enough to sum up to eight full-scale samples.
  localparam int ACC_BITS = ADC_BITS + 3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    LATCH,
    GAP
  } state_t;

endpackage

// File: rtl/adc_reader_if.sv
// ADC serial bus plus the averaged-sample result port of the reader.
interface adc_reader_if;
  import adc_pkg::*;

  logic                adc_cs_n;
  logic                adc_sclk;
  logic                adc_miso;
  logic [ADC_BITS-1:0] adc_data;
  logic                data_valid;
  logic                busy;

  modport master (
    output adc_cs_n, adc_sclk, adc_data, data_valid, busy,
    input  adc_miso
  );

  modport slave (
    input  adc_cs_n, adc_sclk, adc_data, data_valid, busy,
    output adc_miso
  );

endinterface

// File: rtl/sclk_gen.sv
// Clock divider for the ADC serial clock; emits a strobe every CLK_DIV
// cycles while running, and rise/fall strobes when sclk toggling is allowed.
module sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic toggle,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_cnt;

  assign tick = run && (div_cnt == CW'(CLK_DIV - 1));
  assign rise = tick && toggle && !sclk;
  assign fall = tick && toggle && sclk;

  // The divider restarts from zero whenever it is stopped so each phase
  // begins with a full CLK_DIV count.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else begin
      if (!run || tick) div_cnt <= '0;
      else              div_cnt <= div_cnt + 1'b1;

      if (rise)      sclk <= 1'b1;
      else if (fall) sclk <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_reader.sv
// Serial ADC reader: clocks 16-bit samples out of an external ADC and
// averages 2**AVG_LOG2 conversions into each output word.
module adc_reader
  import adc_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int AVG_LOG2 = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  adc_reader_if.master bus
);

  localparam int AVG_COUNT   = 1 << AVG_LOG2;
  localparam int SHIFT_EDGES = 2 * ADC_BITS;

  state_t              state, next_state;
  logic [4:0]          edge_cnt;
  logic                run, toggle, tick, rise, fall, sclk;
  logic [ADC_BITS-1:0] shift_reg, adc_data;
  logic [ACC_BITS-1:0] acc, acc_sum;
  logic [3:0]          sample_cnt;
  logic                valid_pend, data_valid, cs_n, busy;

  sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .toggle (toggle),
    .tick   (tick),
    .rise   (rise),
    .fall   (fall),
    .sclk   (sclk)
  );

  assign acc_sum        = acc + ACC_BITS'(shift_reg);
  assign bus.adc_cs_n   = cs_n;
  assign bus.adc_sclk   = sclk;
  assign bus.adc_data   = adc_data;
  assign bus.data_valid = data_valid;
  assign bus.busy       = busy;

  // cs_n and busy are registered from next_state so they change on the
  // same edge as the state itself, without decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      edge_cnt <= '0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state <= next_state;
      cs_n  <= !(next_state == SETUP || next_state == SHIFT);
      busy  <= (next_state != IDLE);
      if (next_state != state) edge_cnt <= '0;
      else if (tick)           edge_cnt <= edge_cnt + 5'd1;
    end
  end

  always_comb begin
    next_state = state;
    run        = 1'b0;
    toggle     = 1'b0;
    unique case (state)
      IDLE:  if (en) next_state = SETUP;
      SETUP: begin
        run = 1'b1;
        if (tick) next_state = SHIFT;
      end
      SHIFT: begin
        run    = 1'b1;
        toggle = 1'b1;
        if (fall && edge_cnt == 5'(SHIFT_EDGES - 1)) next_state = LATCH;
      end
      LATCH: next_state = GAP;
      GAP: begin
        run = 1'b1;
        if (tick && edge_cnt == 5'(GAP_MULT - 1)) next_state = en ? SETUP : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The accumulator survives en dropping; only reset clears a partial average.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= '0;
      acc        <= '0;
      sample_cnt <= '0;
      adc_data   <= '0;
      valid_pend <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= valid_pend;
      valid_pend <= 1'b0;
      if (rise) shift_reg <= {shift_reg[ADC_BITS-2:0], bus.adc_miso};
      if (state == LATCH) begin
        if (sample_cnt == 4'(AVG_COUNT - 1)) begin
          adc_data   <= ADC_BITS'(acc_sum >> AVG_LOG2);
          acc        <= '0;
          sample_cnt <= '0;
          valid_pend <= 1'b1;
        end else begin
          acc        <= acc_sum;
          sample_cnt <= sample_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_reader.sv
// Directed bench for adc_reader: dut_a runs CLK_DIV=4 without averaging,
// dut_b runs CLK_DIV=2 averaging four conversions per output word.
module tb_adc_reader;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic en_a  = 1'b0;
  logic en_b  = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  adc_reader_if bus_a();
  adc_reader_if bus_b();

  adc_reader #(.CLK_DIV(4), .AVG_LOG2(0)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .en  (en_a),
    .bus (bus_a)
  );

  adc_reader #(.CLK_DIV(2), .AVG_LOG2(2)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .en  (en_b),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  // ADC models: load the next word when cs_n falls, present the MSB first
  // and advance one bit after every falling sclk edge.
  logic [15:0] mem_a [8];
  logic [15:0] mem_b [16];
  logic [15:0] word_a = '0;
  logic [15:0] word_b = '0;
  int ptr_a = 0, ptr_b = 0, bit_a = 16, bit_b = 16;

  always @(negedge bus_a.adc_cs_n) begin
    word_a = mem_a[ptr_a % 8];
    ptr_a++;
    bit_a = 0;
  end
  always @(negedge bus_a.adc_sclk) if (bit_a < 16) bit_a++;
  assign bus_a.adc_miso = (bit_a < 16) ? word_a[15 - bit_a] : 1'b0;

  always @(negedge bus_b.adc_cs_n) begin
    word_b = mem_b[ptr_b % 16];
    ptr_b++;
    bit_b = 0;
  end
  always @(negedge bus_b.adc_sclk) if (bit_b < 16) bit_b++;
  assign bus_b.adc_miso = (bit_b < 16) ? word_b[15 - bit_b] : 1'b0;

  // Bus monitors sampled on the falling clk edge.
  int   valid_cnt_a = 0, valid_cnt_b = 0, double_valid = 0;
  logic prev_valid_a = 1'b0, prev_valid_b = 1'b0;
  int   sclk_cnt_a = 0, sclk_cnt_b = 0, intervals_b = 0;
  int   bad_period_a = 0, bad_period_b = 0;
  logic have_rise_a = 1'b0, have_rise_b = 1'b0;
  logic prev_sclk_a = 1'b0, prev_sclk_b = 1'b0;
  int   cs_run_b = 0, gap_events_b = 0, bad_gap_b = 0;

  always @(negedge clk) begin
    if (bus_a.data_valid === 1'b1) begin
      valid_cnt_a++;
      if (prev_valid_a) double_valid++;
    end
    if (bus_b.data_valid === 1'b1) begin
      valid_cnt_b++;
      if (prev_valid_b) double_valid++;
    end
    prev_valid_a = (bus_a.data_valid === 1'b1);
    prev_valid_b = (bus_b.data_valid === 1'b1);

    sclk_cnt_a++;
    if (bus_a.adc_cs_n !== 1'b0) have_rise_a = 1'b0;
    else if (bus_a.adc_sclk === 1'b1 && !prev_sclk_a) begin
      if (have_rise_a && sclk_cnt_a != 8) bad_period_a++;
      have_rise_a = 1'b1;
      sclk_cnt_a  = 0;
    end
    prev_sclk_a = (bus_a.adc_sclk === 1'b1);

    sclk_cnt_b++;
    if (bus_b.adc_cs_n !== 1'b0) have_rise_b = 1'b0;
    else if (bus_b.adc_sclk === 1'b1 && !prev_sclk_b) begin
      if (have_rise_b) begin
        intervals_b++;
        if (sclk_cnt_b != 4) bad_period_b++;
      end
      have_rise_b = 1'b1;
      sclk_cnt_b  = 0;
    end
    prev_sclk_b = (bus_b.adc_sclk === 1'b1);

    // Quiet time between conversions: LATCH cycle plus 2*CLK_DIV of GAP.
    if (bus_b.busy === 1'b1 && bus_b.adc_cs_n === 1'b1) cs_run_b++;
    else if (bus_b.adc_cs_n === 1'b0 && cs_run_b > 0) begin
      gap_events_b++;
      if (cs_run_b != 5) bad_gap_b++;
      cs_run_b = 0;
    end else cs_run_b = 0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // hold < 0 leaves en high, hold == 0 gives a one-cycle pulse (returns
  // 1 time unit after the sampling edge), hold > 0 keeps en for hold cycles.
  task automatic applyStimulus(input int which, input int hold);
    @(negedge clk);
    if (which == 0) en_a = 1'b1; else en_b = 1'b1;
    if (hold == 0) begin
      @(posedge clk);
      #1;
      if (which == 0) en_a = 1'b0; else en_b = 1'b0;
    end else if (hold > 0) begin
      repeat (hold) @(negedge clk);
      if (which == 0) en_a = 1'b0; else en_b = 1'b0;
    end
  endtask

  task automatic waitValid(input int which, input int budget, output int cycles);
    logic v;
    cycles = 0;
    v = 1'b0;
    while (!v && cycles < budget) begin
      @(negedge clk);
      cycles++;
      v = (which == 0) ? (bus_a.data_valid === 1'b1) : (bus_b.data_valid === 1'b1);
    end
  endtask

  task automatic waitIdle(input int which, input int budget, output int cycles);
    logic b;
    cycles = 0;
    b = 1'b1;
    while (b && cycles < budget) begin
      @(negedge clk);
      cycles++;
      b = (which == 0) ? (bus_a.busy !== 1'b0) : (bus_b.busy !== 1'b0);
    end
  endtask

  initial begin
    int cyc, v0;
    mem_a = '{16'h3081, 16'h1234, 16'hA5C3, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0};
    mem_b = '{16'h0010, 16'h0020, 16'h0030, 16'h0041,
              16'h0000, 16'h0000, 16'h0000, 16'h0000,
              16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
              16'h0100, 16'h0200, 16'h0300, 16'h0400};

    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n", bus_a.adc_cs_n, 1);
    checkOutput("rst_sclk", bus_a.adc_sclk, 0);
    checkOutput("rst_data", bus_a.adc_data, 16'h0000);
    checkOutput("rst_valid", bus_a.data_valid, 0);
    checkOutput("rst_busy", bus_a.busy, 0);
    checkOutput("rst_data_b", bus_b.adc_data, 16'h0000);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idle_wait_busy", bus_a.busy, 0);
    checkOutput("idle_wait_cs_n", bus_a.adc_cs_n, 1);

    // Single-cycle en pulse: 33*4+2 cycles from the sampling edge to data_valid.
    $display("[TB] single conversion, CLK_DIV=4");
    v0 = valid_cnt_a;
    applyStimulus(0, 0);
    checkOutput("start_cs_n", bus_a.adc_cs_n, 0);
    checkOutput("start_busy", bus_a.busy, 1);
    waitValid(0, 400, cyc);
    checkOutput("latency", cyc, 1 + 134);
    checkOutput("data_3081", bus_a.adc_data, 16'h3081);
    waitIdle(0, 50, cyc);
    checkOutput("gap_to_idle", cyc, 7);
    checkOutput("idle_cs_n", bus_a.adc_cs_n, 1);
    checkOutput("idle_sclk", bus_a.adc_sclk, 0);
    checkOutput("valid_once", valid_cnt_a - v0, 1);

    // en dropped mid-SHIFT: conversion still completes exactly once.
    $display("[TB] en dropped during SHIFT");
    v0 = valid_cnt_a;
    applyStimulus(0, 40);
    waitIdle(0, 400, cyc);
    repeat (20) @(negedge clk);
    checkOutput("drop_valid_once", valid_cnt_a - v0, 1);
    checkOutput("drop_data", bus_a.adc_data, 16'h1234);
    checkOutput("drop_cs_n", bus_a.adc_cs_n, 1);
    checkOutput("drop_busy", bus_a.busy, 0);

    // Reset after eight bits have been shifted, then a clean conversion.
    $display("[TB] reset during SHIFT");
    applyStimulus(0, 0);
    cyc = 0;
    while (bit_a != 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reach_bit7", (bit_a == 8), 1);
    rst_a = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_cs_n", bus_a.adc_cs_n, 1);
    checkOutput("mid_rst_sclk", bus_a.adc_sclk, 0);
    checkOutput("mid_rst_data", bus_a.adc_data, 16'h0000);
    checkOutput("mid_rst_valid", bus_a.data_valid, 0);
    checkOutput("mid_rst_busy", bus_a.busy, 0);
    rst_a = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("post_rst_idle", bus_a.busy, 0);
    applyStimulus(0, 0);
    waitValid(0, 400, cyc);
    checkOutput("clean_latency", cyc, 1 + 134);
    checkOutput("clean_ffff", bus_a.adc_data, 16'hFFFF);

    // dut_b: continuous run; each output averages four conversions of 71 cycles.
    $display("[TB] averaged continuous run, CLK_DIV=2");
    applyStimulus(1, -1);
    waitValid(1, 600, cyc);
    checkOutput("avg_latency", cyc, 1 + 3 * 71 + 68);
    // (0x10 + 0x20 + 0x30 + 0x41) >> 2 = 0xA1 >> 2 = 0x28
    checkOutput("avg_0028", bus_b.adc_data, 16'h0028);
    waitValid(1, 600, cyc);
    checkOutput("avg_period", cyc, 4 * 71);
    checkOutput("avg_zero", bus_b.adc_data, 16'h0000);
    waitValid(1, 600, cyc);
    en_b = 1'b0;
    checkOutput("avg_ffff", bus_b.adc_data, 16'hFFFF);
    waitIdle(1, 50, cyc);
    checkOutput("b_idle_sclk", bus_b.adc_sclk, 0);
    checkOutput("b_idle_cs_n", bus_b.adc_cs_n, 1);

    // Partial average survives en dropping between runs.
    $display("[TB] partial average kept across runs");
    v0 = valid_cnt_b;
    applyStimulus(1, 100);
    waitIdle(1, 300, cyc);
    repeat (5) @(negedge clk);
    checkOutput("partial_no_valid", valid_cnt_b - v0, 0);
    applyStimulus(1, 100);
    waitIdle(1, 300, cyc);
    repeat (5) @(negedge clk);
    checkOutput("partial_valid", valid_cnt_b - v0, 1);
    // (0x100 + 0x200 + 0x300 + 0x400) >> 2 = 0xA00 >> 2 = 0x280
    checkOutput("partial_0280", bus_b.adc_data, 16'h0280);

    checkOutput("no_double_valid", double_valid, 0);
    checkOutput("valid_total_a", valid_cnt_a, 3);
    checkOutput("valid_total_b", valid_cnt_b, 4);
    checkOutput("sclk_period_a", bad_period_a, 0);
    checkOutput("sclk_period_b", bad_period_b, 0);
    checkOutput("sclk_intervals_b", intervals_b, 16 * 15);
    checkOutput("cs_gap_events", gap_events_b, 13);
    checkOutput("cs_gap_len", bad_gap_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
